// File: rtl/exception_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: cause codes,
// CP0 register addresses, flag-vector bit positions and handler layout.
package exception_ctrl_pkg;

  localparam logic [4:0] EXC_CODE_INT  = 5'h00;
  localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
  localparam logic [4:0] EXC_CODE_ADES = 5'h05;
  localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
  localparam logic [4:0] EXC_CODE_BP   = 5'h09;
  localparam logic [4:0] EXC_CODE_RI   = 5'h0a;
  localparam logic [4:0] EXC_CODE_OV   = 5'h0c;
  localparam logic [4:0] EXC_CODE_TR   = 5'h0d;
  localparam logic [4:0] EXC_CODE_ERET = 5'h0e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam logic [4:0] CP0_REG_EBASE  = 5'd15;
  localparam logic [2:0] CP0_SEL_0      = 3'd0;
  localparam logic [2:0] CP0_SEL_EBASE  = 3'd1;

  localparam int EXC_BIT_FETCH_ADEL = 0;
  localparam int EXC_BIT_RI         = 1;
  localparam int EXC_BIT_OV         = 2;
  localparam int EXC_BIT_TR         = 3;
  localparam int EXC_BIT_SYS        = 4;
  localparam int EXC_BIT_BP         = 5;
  localparam int EXC_BIT_ERET       = 6;
  localparam int EXC_BIT_LOAD_ADEL  = 7;
  localparam int EXC_BIT_ADES       = 8;

  localparam logic [31:0] EXC_HANDLER_OFS = 32'h0000_0180;
  localparam logic [31:0] EXC_BASE_FIXED  = 32'hBFC0_0200;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HOLD     = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exception_ctrl_prio_enc.sv
// Per-slot exception priority encoder: interrupt first, then the flag
// vector from fetch ADEL down to store ADES.
module exc_prio_enc
  import exception_ctrl_pkg::*;
#(
  parameter int EXC_VEC_W = 9
) (
  input  logic                 valid_i,
  input  logic                 int_i,
  input  logic [EXC_VEC_W-1:0] exc_vec_i,
  output logic                 has_exc_o,
  output logic [4:0]           code_o,
  output logic                 eret_o
);

  always_comb begin
    has_exc_o = 1'b1;
    code_o    = EXC_CODE_INT;
    eret_o    = 1'b0;
    if (int_i) begin
      code_o = EXC_CODE_INT;
    end else if (!valid_i) begin
      has_exc_o = 1'b0;
    end else if (exc_vec_i[EXC_BIT_FETCH_ADEL]) begin
      code_o = EXC_CODE_ADEL;
    end else if (exc_vec_i[EXC_BIT_RI]) begin
      code_o = EXC_CODE_RI;
    end else if (exc_vec_i[EXC_BIT_OV]) begin
      code_o = EXC_CODE_OV;
    end else if (exc_vec_i[EXC_BIT_TR]) begin
      code_o = EXC_CODE_TR;
    end else if (exc_vec_i[EXC_BIT_SYS]) begin
      code_o = EXC_CODE_SYS;
    end else if (exc_vec_i[EXC_BIT_BP]) begin
      code_o = EXC_CODE_BP;
    end else if (exc_vec_i[EXC_BIT_ERET]) begin
      code_o = EXC_CODE_ERET;
      eret_o = 1'b1;
    end else if (exc_vec_i[EXC_BIT_LOAD_ADEL]) begin
      code_o = EXC_CODE_ADEL;
    end else if (exc_vec_i[EXC_BIT_ADES]) begin
      code_o = EXC_CODE_ADES;
    end else begin
      has_exc_o = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Dual-slot MEM-stage exception controller with registered redirect FSM.
// Optional macro EXC_EBASE_EN: handler base taken from CP0 EBase.
//
// state       | meaning
// IDLE        | accepting exceptions/interrupts
// REDIRECT    | first flush cycle, new_pc_o presented to fetch
// HOLD        | fetch stalled, flush and new_pc_o held until it accepts
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter int EXC_VEC_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i1,
  input  logic                 valid_i2,
  input  logic [31:0]          pc_i1,
  input  logic [31:0]          pc_i2,
  input  logic                 dslot_i1,
  input  logic                 dslot_i2,
  input  logic [EXC_VEC_W-1:0] exc_vec_i1,
  input  logic [EXC_VEC_W-1:0] exc_vec_i2,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          cp0_status_i,
  input  logic [31:0]          cp0_cause_i,
  input  logic [31:0]          cp0_epc_i,
  input  logic [31:0]          cp0_ebase_i,
  input  logic                 cp0_we_i,
  input  logic [4:0]           cp0_waddr_i,
  input  logic [2:0]           cp0_wsel_i,
  input  logic [31:0]          cp0_wdata_i,
  input  logic                 mem_stall_i,
  input  logic                 if_stall_i,
  output logic                 exception_flag_o,
  output logic [4:0]           excepttype_o,
  output logic                 exception_inst_sel_o,
  output logic [31:0]          exc_mem_addr_o,
  output logic                 flush_o,
  output logic [31:0]          new_pc_o,
  output logic                 busy_o
);

  logic [31:0] status_eff, cause_eff, epc_eff, handler_base, target;
  logic        wr_sel0, int_pend, int1, int2;
  logic        has1, has2, eret1, eret2, exc_accept;
  logic [4:0]  code1, code2;
  logic        unused_sig;

  exc_state_e  state_q, state_d;
  logic        flush_q, flush_d, busy_q, busy_d;
  logic [31:0] new_pc_q, new_pc_d;

  // mtc0 in the same cycle must be visible to the exception decision
  assign wr_sel0    = cp0_we_i && (cp0_wsel_i == CP0_SEL_0);
  assign status_eff = (wr_sel0 && cp0_waddr_i == CP0_REG_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign cause_eff  = (wr_sel0 && cp0_waddr_i == CP0_REG_CAUSE)
                      ? {cp0_cause_i[31:10], cp0_wdata_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;
  assign epc_eff    = (wr_sel0 && cp0_waddr_i == CP0_REG_EPC) ? cp0_wdata_i : cp0_epc_i;

  assign int_pend = (|(cause_eff[15:8] & status_eff[15:8])) && status_eff[0] && !status_eff[1];
  assign int1     = int_pend && valid_i1;
  assign int2     = int_pend && !valid_i1 && valid_i2;

`ifdef EXC_EBASE_EN
  logic [31:0] ebase_eff;
  assign ebase_eff    = (cp0_we_i && cp0_waddr_i == CP0_REG_EBASE && cp0_wsel_i == CP0_SEL_EBASE)
                        ? cp0_wdata_i : cp0_ebase_i;
  assign handler_base = {ebase_eff[31:12], 12'h000};
  assign unused_sig   = ^{pc_i1, pc_i2, dslot_i1, dslot_i2, ebase_eff[11:0],
                          status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};
`else
  assign handler_base = EXC_BASE_FIXED;
  assign unused_sig   = ^{pc_i1, pc_i2, dslot_i1, dslot_i2, cp0_ebase_i,
                          status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};
`endif

  exc_prio_enc #(.EXC_VEC_W(EXC_VEC_W)) u_enc1 (
    .valid_i   (valid_i1),
    .int_i     (int1),
    .exc_vec_i (exc_vec_i1),
    .has_exc_o (has1),
    .code_o    (code1),
    .eret_o    (eret1)
  );

  exc_prio_enc #(.EXC_VEC_W(EXC_VEC_W)) u_enc2 (
    .valid_i   (valid_i2),
    .int_i     (int2),
    .exc_vec_i (exc_vec_i2),
    .has_exc_o (has2),
    .code_o    (code2),
    .eret_o    (eret2)
  );

  assign exc_accept = !rst && (state_q == ST_IDLE) && !mem_stall_i && (has1 || has2);
  assign target     = (has1 ? eret1 : eret2) ? epc_eff : handler_base + EXC_HANDLER_OFS;

  assign exception_flag_o     = exc_accept;
  assign excepttype_o         = exc_accept ? (has1 ? code1 : code2) : 5'h00;
  assign exception_inst_sel_o = rst ? 1'b0 : (exc_accept ? has1 : 1'b1);
  assign exc_mem_addr_o       = rst ? 32'h0 : mem_addr_i;

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    busy_d   = busy_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_IDLE: begin
        flush_d = 1'b0;
        busy_d  = 1'b0;
        if (exc_accept) begin
          state_d  = ST_REDIRECT;
          flush_d  = 1'b1;
          busy_d   = 1'b1;
          new_pc_d = target;
        end
      end
      ST_REDIRECT, ST_HOLD: begin
        if (if_stall_i) begin
          state_d = ST_HOLD;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      new_pc_q <= new_pc_d;
    end
  end

  assign flush_o  = flush_q;
  assign busy_o   = busy_q;
  assign new_pc_o = new_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl (default and EXC_EBASE_EN builds).
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i1, valid_i2, dslot_i1, dslot_i2;
  logic [31:0] pc_i1, pc_i2, mem_addr_i;
  logic [8:0]  exc_vec_i1, exc_vec_i2;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i, cp0_wdata_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [2:0]  cp0_wsel_i;
  logic        mem_stall_i, if_stall_i;
  logic        exception_flag_o, exception_inst_sel_o, flush_o, busy_o;
  logic [4:0]  excepttype_o;
  logic [31:0] exc_mem_addr_o, new_pc_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef EXC_EBASE_EN
  localparam logic [31:0] HANDLER = 32'h8000_0180;
`else
  localparam logic [31:0] HANDLER = 32'hBFC0_0380;
`endif

  exception_ctrl #(.EXC_VEC_W(9)) dut (
    .clk(clk), .rst(rst),
    .valid_i1(valid_i1), .valid_i2(valid_i2),
    .pc_i1(pc_i1), .pc_i2(pc_i2),
    .dslot_i1(dslot_i1), .dslot_i2(dslot_i2),
    .exc_vec_i1(exc_vec_i1), .exc_vec_i2(exc_vec_i2),
    .mem_addr_i(mem_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
    .cp0_wsel_i(cp0_wsel_i), .cp0_wdata_i(cp0_wdata_i),
    .mem_stall_i(mem_stall_i), .if_stall_i(if_stall_i),
    .exception_flag_o(exception_flag_o), .excepttype_o(excepttype_o),
    .exception_inst_sel_o(exception_inst_sel_o), .exc_mem_addr_o(exc_mem_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    valid_i1 = 0; valid_i2 = 0; dslot_i1 = 0; dslot_i2 = 0;
    pc_i1 = 32'hBFC0_0100; pc_i2 = 32'hBFC0_0104; mem_addr_i = 32'h1234_5678;
    exc_vec_i1 = '0; exc_vec_i2 = '0;
    cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0; cp0_ebase_i = 32'h8000_0ABC;
    cp0_we_i = 0; cp0_waddr_i = 0; cp0_wsel_i = 0; cp0_wdata_i = 0;
    mem_stall_i = 0;
  endtask

  initial begin
    quiet();
    if_stall_i = 0;
    rst = 1;
    step();
    chk("rst_flush", {31'b0, flush_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_newpc", new_pc_o, 32'h0);
    valid_i1 = 1; exc_vec_i1 = 9'h002; #1;
    chk("rst_flag_forced", {31'b0, exception_flag_o}, 0);
    chk("rst_type_forced", {27'b0, excepttype_o}, 0);
    quiet();
    step();
    rst = 0;
    #1;
    chk("idle_flag", {31'b0, exception_flag_o}, 0);
    chk("idle_sel", {31'b0, exception_inst_sel_o}, 1);

    // RI in slot 1
    valid_i1 = 1; exc_vec_i1 = 9'h002; #1;
    chk("ri_flag", {31'b0, exception_flag_o}, 1);
    chk("ri_type", {27'b0, excepttype_o}, 32'h0a);
    chk("ri_sel", {31'b0, exception_inst_sel_o}, 1);
    chk("memaddr_pass", exc_mem_addr_o, 32'h1234_5678);
    step();
    chk("ri_flush", {31'b0, flush_o}, 1);
    chk("ri_busy", {31'b0, busy_o}, 1);
    chk("ri_newpc", new_pc_o, HANDLER);
    chk("redirect_ignores", {31'b0, exception_flag_o}, 0);
    quiet();
    step();
    chk("ri_flush_done", {31'b0, flush_o}, 0);
    chk("ri_busy_done", {31'b0, busy_o}, 0);

    // slot selection and priority (combinational only)
    valid_i1 = 1; valid_i2 = 1; exc_vec_i2 = 9'h014; #1;
    chk("s2_type", {27'b0, excepttype_o}, 32'h0c);
    chk("s2_sel", {31'b0, exception_inst_sel_o}, 0);
    exc_vec_i1 = 9'h020; #1;
    chk("both_type", {27'b0, excepttype_o}, 32'h09);
    chk("both_sel", {31'b0, exception_inst_sel_o}, 1);
    exc_vec_i1 = 9'h108; #1;
    chk("tr_over_ades", {27'b0, excepttype_o}, 32'h0d);
    exc_vec_i1 = 9'h180; #1;
    chk("ladel_over_ades", {27'b0, excepttype_o}, 32'h04);
    exc_vec_i1 = 9'h100; #1;
    chk("ades", {27'b0, excepttype_o}, 32'h05);
    exc_vec_i1 = 9'h011; #1;
    chk("fadel_over_sys", {27'b0, excepttype_o}, 32'h04);
    valid_i1 = 0; valid_i2 = 0; #1;
    chk("invalid_ignored", {31'b0, exception_flag_o}, 0);
    quiet();

    // ERET with EPC bypass
    valid_i1 = 1; exc_vec_i1 = 9'h040; cp0_epc_i = 32'h8000_1000;
    cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wsel_i = 0; cp0_wdata_i = 32'h8000_2000; #1;
    chk("eret_type", {27'b0, excepttype_o}, 32'h0e);
    step();
    quiet();
    chk("eret_newpc", new_pc_o, 32'h8000_2000);
    step();

    // interrupts
    valid_i1 = 1; cp0_status_i = 32'h0000_FF01; cp0_cause_i = 32'h0000_0400; #1;
    chk("int_flag", {31'b0, exception_flag_o}, 1);
    chk("int_type", {27'b0, excepttype_o}, 32'h00);
    exc_vec_i1 = 9'h001; #1;
    chk("int_over_adel", {27'b0, excepttype_o}, 32'h00);
    exc_vec_i1 = 0;
    cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000_FF03; #1;
    chk("int_exl_masked", {31'b0, exception_flag_o}, 0);
    cp0_cause_i = 0; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h0000_0100; #1;
    chk("int_cause_bypass", {31'b0, exception_flag_o}, 1);
    cp0_wdata_i = 32'h0000_0400; #1;
    chk("int_cause_bits_9_8_only", {31'b0, exception_flag_o}, 0);
    cp0_we_i = 0; cp0_cause_i = 32'h0000_0400; valid_i1 = 0; valid_i2 = 1; #1;
    chk("int_slot2_sel", {31'b0, exception_inst_sel_o}, 0);
    chk("int_slot2_flag", {31'b0, exception_flag_o}, 1);
    valid_i2 = 0; #1;
    chk("int_no_slot", {31'b0, exception_flag_o}, 0);
    quiet();

    // fetch stall holds redirect for 4 flush cycles
    valid_i1 = 1; exc_vec_i1 = 9'h004; #1;
    chk("ov_flag", {31'b0, exception_flag_o}, 1);
    step();
    if_stall_i = 1; exc_vec_i1 = 9'h002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_flush", {31'b0, flush_o}, 1);
      chk("stall_flag", {31'b0, exception_flag_o}, 0);
      step();
    end
    if_stall_i = 0; quiet(); #1;
    chk("stall_flush4", {31'b0, flush_o}, 1);
    chk("stall_newpc", new_pc_o, HANDLER);
    step();
    chk("stall_released", {31'b0, flush_o}, 0);

    // MEM stall defers the exception
    valid_i1 = 1; exc_vec_i1 = 9'h002; mem_stall_i = 1; #1;
    chk("memstall_noflag", {31'b0, exception_flag_o}, 0);
    step();
    chk("memstall_noflush", {31'b0, flush_o}, 0);
    mem_stall_i = 0; #1;
    chk("memstall_drop_flag", {31'b0, exception_flag_o}, 1);
    step();
    quiet(); if_stall_i = 1;
    step();
    chk("hold_flush", {31'b0, flush_o}, 1);
    rst = 1;
    step();
    rst = 0; if_stall_i = 0; #1;
    chk("rst_hold_flush", {31'b0, flush_o}, 0);
    chk("rst_hold_busy", {31'b0, busy_o}, 0);
    chk("rst_hold_newpc", new_pc_o, 32'h0);
    step();
    chk("post_rst_flush", {31'b0, flush_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
